mem_req_ctrl: RTL

//  Memory request controller between the multi-cycle CPU's memory port and a synchronous word SRAM.

---
 rtl/mem_ctrl_pkg.sv | 13 +
 rtl/wr_buf_fifo.sv | 61 ++++++
 rtl/mem_req_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory request controller: read FSM states and the wait-counter width.
package mem_ctrl_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_PEND = 2'd1,
        RD_WAIT = 2'd2,
        RSP     = 2'd3
    } rd_state_e;

endpackage

// File: rtl/wr_buf_fifo.sv
// Posted-write buffer: power-of-2 deep synchronous FIFO with wrapping pointers and an occupancy count.
module wr_buf_fifo #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 40,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W:0]   o_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (count_q == (PTR_W+1)'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    // Simultaneous push and pop leaves the occupancy unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= i_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// CPU-to-SRAM request controller: posted writes drain in the background, reads wait for the
// buffer to empty, each SRAM strobe is followed by WAIT_CYC busy cycles.
module mem_req_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MEM_AW   = 8,
    parameter int unsigned WAIT_CYC = 2,
    parameter int unsigned WB_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_misalign,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int unsigned ENT_W  = MEM_AW + DATA_W;
    localparam int unsigned WB_PW  = $clog2(WB_DEPTH);
    localparam logic [CNT_W-1:0] WAIT_V = CNT_W'(WAIT_CYC);

    rd_state_e         state_q, state_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [MEM_AW-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              misalign_q, misalign_d;

    logic              accept;
    logic              aligned;
    logic [MEM_AW-1:0] req_waddr;
    logic              port_free;
    logic              rd_strobe;
    logic              wb_push;
    logic              wb_pop;
    logic              wb_full;
    logic              wb_empty;
    logic [ENT_W-1:0]  wb_head;
    logic [WB_PW:0]    wb_count;
    logic              unused_bits;

    assign accept    = i_req_valid && o_req_ready;
    assign aligned   = (i_req_addr[1:0] == 2'b00);
    assign req_waddr = i_req_addr[MEM_AW+1:2];
    assign port_free = (wait_q == '0);
    assign wb_push   = accept && i_req_we && aligned;
    // Drain runs regardless of FSM state; gated by reset so nothing reaches the SRAM then.
    assign wb_pop    = port_free && !wb_empty && !i_rst;
    assign unused_bits = ^{i_req_addr[ADDR_W-1:MEM_AW+2], wb_count};

    wr_buf_fifo #(
        .DEPTH (WB_DEPTH),
        .WIDTH (ENT_W)
    ) u_wr_buf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (wb_push),
        .i_pop   (wb_pop),
        .i_data  ({req_waddr, i_req_wdata}),
        .o_head  (wb_head),
        .o_full  (wb_full),
        .o_empty (wb_empty),
        .o_count (wb_count)
    );

    // Read FSM, port-busy counter and sticky misalignment flag.
    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_addr_d  = rd_addr_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        misalign_d = misalign_q;
        rd_strobe  = 1'b0;
        wait_d     = port_free ? wait_q : (wait_q - CNT_W'(1));

        if (accept && !aligned) begin
            misalign_d = 1'b1;
        end
        if (wb_pop) begin
            wait_d = WAIT_V;
        end

        case (state_q)
            IDLE: begin
                if (accept && !i_req_we) begin
                    if (aligned) begin
                        rd_addr_d = req_waddr;
                        state_d   = RD_PEND;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RSP;
                    end
                end
            end
            RD_PEND: begin
                if (wb_empty && port_free && !i_rst) begin
                    rd_strobe = 1'b1;
                    wait_d    = WAIT_V;
                    rd_cnt_d  = WAIT_V;
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_cnt_q == '0) begin
                    rdata_d = i_mem_rdata;
                    err_d   = 1'b0;
                    state_d = RSP;
                end else begin
                    rd_cnt_d = rd_cnt_q - CNT_W'(1);
                end
            end
            RSP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            rd_cnt_q   <= '0;
            rd_addr_q  <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_addr_q  <= rd_addr_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            misalign_q <= misalign_d;
        end
    end

    assign o_req_ready = (state_q == IDLE) && !wb_full;
    assign o_rsp_valid = (state_q == RSP);
    assign o_rsp_err   = o_rsp_valid && err_q;
    assign o_rsp_rdata = rdata_q;
    assign o_misalign  = misalign_q;

    // SRAM port: buffered write and read strobe never coincide (reads need an empty buffer).
    assign o_mem_en    = wb_pop || rd_strobe;
    assign o_mem_we    = wb_pop;
    assign o_mem_addr  = wb_pop    ? wb_head[ENT_W-1:DATA_W] :
                         rd_strobe ? rd_addr_q : '0;
    assign o_mem_wdata = wb_pop ? wb_head[DATA_W-1:0] : '0;

endmodule
